// File: rtl/fb_fetch_scheduler.sv
// Framebuffer scanline fetch scheduler: issues AXI4 read bursts per line,
// tracks outstanding bursts, and double-buffers the displayed framebuffer.
module fb_fetch_scheduler #(
  parameter logic [31:0] FB0_BASE        = 32'h81000000,
  parameter logic [31:0] FB1_BASE        = 32'h8112C000,
  parameter int          BURST_LEN       = 64,
  parameter int          BURSTS_PER_LINE = 5,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        m00_axi_aclk,
  input  logic        m00_axi_areset,
  input  logic        line_req,
  input  logic [8:0]  line_idx,
  input  logic        frame_start,
  input  logic        swap_req,
  output logic        m00_axi_arid,
  output logic [31:0] m00_axi_araddr,
  output logic [7:0]  m00_axi_arlen,
  output logic [2:0]  m00_axi_arsize,
  output logic [1:0]  m00_axi_arburst,
  output logic        m00_axi_arvalid,
  input  logic        m00_axi_arready,
  input  logic        m00_axi_rvalid,
  input  logic        m00_axi_rready,
  input  logic        m00_axi_rlast,
  output logic        busy,
  output logic        line_done,
  output logic        active_fb,
  output logic        swap_pending,
  output logic        err
);

  localparam int BW = $clog2(BURSTS_PER_LINE + 1);
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 8);
  localparam logic [31:0] LINE_BYTES  = 32'(BURST_LEN * 8 * BURSTS_PER_LINE);
  localparam logic [8:0]  LAST_LINE   = 9'd479;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [8:0]    lidx_q, lidx_d;
  logic          lfb_q, lfb_d;
  logic [BW-1:0] bidx_q, bidx_d;
  logic [1:0]    outs_q, outs_d;
  logic          done_q, done_d;
  logic          afb_q, afb_d;
  logic          swp_q, swp_d;
  logic          err_q, err_d;
  logic          armed_q, armed_d;

  logic          hs;
  logic          cpl;
  logic          dec;
  logic [31:0]   addr;

  assign m00_axi_arid    = 1'b0;
  assign m00_axi_arlen   = 8'(BURST_LEN - 1);
  assign m00_axi_arsize  = 3'b011;
  assign m00_axi_arburst = 2'b01;

  assign m00_axi_arvalid = (state_q == S_ISSUE)
                        && (bidx_q < BW'(BURSTS_PER_LINE))
                        && (outs_q < 2'(MAX_OUTSTANDING));

  assign addr = (lfb_q ? FB1_BASE : FB0_BASE)
              + 32'(lidx_q) * LINE_BYTES
              + 32'(bidx_q) * BURST_BYTES;

  // Address is only meaningful alongside arvalid; park it at zero otherwise
  assign m00_axi_araddr = m00_axi_arvalid ? addr : 32'd0;

  assign hs  = m00_axi_arvalid & m00_axi_arready;
  assign cpl = m00_axi_rvalid & m00_axi_rready & m00_axi_rlast;
  assign dec = cpl && (outs_q != 2'd0);

  assign busy         = (state_q != S_IDLE);
  assign line_done    = done_q;
  assign active_fb    = afb_q;
  assign swap_pending = swp_q;
  assign err          = err_q;

  always_comb begin
    state_d = state_q;
    lidx_d  = lidx_q;
    lfb_d   = lfb_q;
    bidx_d  = bidx_q;
    done_d  = 1'b0;
    err_d   = err_q;
    armed_d = armed_q;
    outs_d  = outs_q + 2'(hs) - 2'(dec);
    afb_d   = afb_q;
    swp_d   = swp_q | swap_req;

    if (line_req && (state_q != S_IDLE || line_idx > LAST_LINE))
      err_d = 1'b1;
    // Stray completions only count as errors once a line has been accepted
    if (cpl && outs_q == 2'd0 && armed_q)
      err_d = 1'b1;

    if (frame_start && swp_d) begin
      afb_d = ~afb_q;
      swp_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (line_req && line_idx <= LAST_LINE) begin
          state_d = S_ISSUE;
          lidx_d  = line_idx;
          lfb_d   = afb_q;
          bidx_d  = '0;
          armed_d = 1'b1;
        end
      end
      S_ISSUE: begin
        if (hs) begin
          bidx_d = bidx_q + BW'(1);
          if (bidx_q == BW'(BURSTS_PER_LINE - 1))
            state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (outs_d == 2'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
    if (m00_axi_areset) begin
      state_q <= S_IDLE;
      lidx_q  <= '0;
      lfb_q   <= 1'b0;
      bidx_q  <= '0;
      outs_q  <= '0;
      done_q  <= 1'b0;
      afb_q   <= 1'b0;
      swp_q   <= 1'b0;
      err_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lidx_q  <= lidx_d;
      lfb_q   <= lfb_d;
      bidx_q  <= bidx_d;
      outs_q  <= outs_d;
      done_q  <= done_d;
      afb_q   <= afb_d;
      swp_q   <= swp_d;
      err_q   <= err_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: tb/tb_fb_fetch_scheduler.sv
// Directed bench for fb_fetch_scheduler with a simple AXI R-channel slave
// that returns 64 beats per accepted burst.
module tb_fb_fetch_scheduler;

  logic        clk;
  logic        rst;
  logic        line_req;
  logic [8:0]  line_idx;
  logic        frame_start;
  logic        swap_req;
  logic        arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic        rvalid;
  logic        rready;
  logic        rlast;
  logic        busy;
  logic        line_done;
  logic        active_fb;
  logic        swap_pending;
  logic        err;

  fb_fetch_scheduler dut (
    .m00_axi_aclk    (clk),
    .m00_axi_areset  (rst),
    .line_req        (line_req),
    .line_idx        (line_idx),
    .frame_start     (frame_start),
    .swap_req        (swap_req),
    .m00_axi_arid    (arid),
    .m00_axi_araddr  (araddr),
    .m00_axi_arlen   (arlen),
    .m00_axi_arsize  (arsize),
    .m00_axi_arburst (arburst),
    .m00_axi_arvalid (arvalid),
    .m00_axi_arready (arready),
    .m00_axi_rvalid  (rvalid),
    .m00_axi_rready  (rready),
    .m00_axi_rlast   (rlast),
    .busy            (busy),
    .line_done       (line_done),
    .active_fb       (active_fb),
    .swap_pending    (swap_pending),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] addr_log[$];
  int          ld_cnt = 0;
  int          mo = 0;
  int          max_mo = 0;
  int          pend = 0;
  int          beat = 0;
  logic        r_en = 1'b0;
  int          stray_req = 0;
  int          stray_done = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    tick();
  endtask

  task automatic chk_line(string tag, int base, logic [31:0] a0);
    chk({tag, "_nhs"}, 32'(addr_log.size() - base), 32'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("%s_addr%0d", tag, i), addr_log[base + i],
          a0 + 32'(i) * 32'h200);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_arvalid"}, 32'(arvalid), 32'd0);
    chk({tag, "_araddr"}, araddr, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(line_done), 32'd0);
    chk({tag, "_afb"}, 32'(active_fb), 32'd0);
    chk({tag, "_swp"}, 32'(swap_pending), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic req_line(logic [8:0] idx);
    line_idx = idx;
    line_req = 1'b1;
    tick();
    line_req = 1'b0;
  endtask

  // AR monitor and R-channel slave, driven away from the active edge
  initial begin
    rvalid = 1'b0;
    rlast  = 1'b0;
    forever begin
      @(negedge clk);
      if (line_done) ld_cnt++;
      rvalid = 1'b0;
      rlast  = 1'b0;
      if (r_en && pend > 0) begin
        rvalid = 1'b1;
        if (beat == 63) begin
          rlast = 1'b1;
          beat  = 0;
          pend--;
          if (mo > 0) mo--;
        end else begin
          beat++;
        end
      end else if (stray_req != stray_done) begin
        rvalid = 1'b1;
        rlast  = 1'b1;
        stray_done++;
      end
      if (!rst && arvalid && arready) begin
        addr_log.push_back(araddr);
        pend++;
        mo++;
      end
      if (mo > max_mo) max_mo = mo;
      if (rst) mo = 0;
    end
  end

  int base;
  int ld0;
  int n;

  initial begin
    rst         = 1'b1;
    line_req    = 1'b0;
    line_idx    = '0;
    frame_start = 1'b0;
    swap_req    = 1'b0;
    arready     = 1'b0;
    rready      = 1'b1;
    tick();
    tick();
    chk_reset_vals("rst");
    chk("arid", 32'(arid), 32'd0);
    chk("arlen", 32'(arlen), 32'd63);
    chk("arsize", 32'(arsize), 32'd3);
    chk("arburst", 32'(arburst), 32'd1);
    rst = 1'b0;
    tick();

    // Line 0 with free-flowing AR and R
    arready = 1'b1;
    r_en    = 1'b1;
    base    = addr_log.size();
    ld0     = ld_cnt;
    req_line(9'd0);
    chk("l0_arvalid1", 32'(arvalid), 32'd1);
    chk("l0_busy", 32'(busy), 32'd1);
    wait_done("l0");
    chk_line("l0", base, 32'h81000000);
    chk("l0_ldcnt", 32'(ld_cnt - ld0), 32'd1);
    chk("l0_err", 32'(err), 32'd0);

    // Line 479 with AR stalled for 10 cycles
    arready = 1'b0;
    base    = addr_log.size();
    req_line(9'd479);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("l479_arv%0d", i), 32'(arvalid), 32'd1);
      chk($sformatf("l479_ara%0d", i), araddr, 32'h8112B600);
      tick();
    end
    arready = 1'b1;
    wait_done("l479");
    chk_line("l479", base, 32'h8112B600);

    // Framebuffer swap then line 1 from fb1
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("swp_set", 32'(swap_pending), 32'd1);
    chk("swp_afb0", 32'(active_fb), 32'd0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("swp_afb1", 32'(active_fb), 32'd1);
    chk("swp_clr", 32'(swap_pending), 32'd0);
    base = addr_log.size();
    req_line(9'd1);
    chk("l1_first", araddr, 32'h8112CA00);
    wait_done("l1");
    chk_line("l1", base, 32'h8112CA00);

    // Request while busy is dropped
    base = addr_log.size();
    ld0  = ld_cnt;
    req_line(9'd2);
    req_line(9'd5);
    chk("busyreq_err", 32'(err), 32'd1);
    wait_done("l2");
    chk_line("l2", base, 32'h8112D400);
    chk("l2_ldcnt", 32'(ld_cnt - ld0), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("l2_noextra", 32'(addr_log.size() - base), 32'd5);

    // Out-of-range line index
    do_reset();
    req_line(9'd480);
    chk("l480_err", 32'(err), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("l480_arv%0d", i), 32'(arvalid), 32'd0);
      chk($sformatf("l480_busy%0d", i), 32'(busy), 32'd0);
      tick();
    end

    // Reset after the second AR handshake
    do_reset();
    r_en = 1'b0;
    base = addr_log.size();
    req_line(9'd3);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    req_line(9'd7);
    n = 0;
    while (addr_log.size() - base < 2 && n < 100) begin
      tick();
      n++;
    end
    chk("mid_nhs", 32'(addr_log.size() - base), 32'd2);
    chk("mid_err_pre", 32'(err), 32'd1);
    rst = 1'b1;
    tick();
    chk_reset_vals("mid_rst");
    rst  = 1'b0;
    r_en = 1'b1;
    base = addr_log.size();
    for (int i = 0; i < 140; i++) tick();
    chk("stale_err", 32'(err), 32'd0);
    chk("stale_nhs", 32'(addr_log.size() - base), 32'd0);
    ld0 = ld_cnt;
    req_line(9'd3);
    chk("l3_first", araddr, 32'h81001E00);
    wait_done("l3");
    chk_line("l3", base, 32'h81001E00);
    chk("l3_ldcnt", 32'(ld_cnt - ld0), 32'd1);
    chk("l3_err", 32'(err), 32'd0);

    // Completion with nothing outstanding
    stray_req++;
    for (int i = 0; i < 3; i++) tick();
    chk("stray_err", 32'(err), 32'd1);

    chk("max_outstanding_le2", 32'(max_mo <= 2), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fb_fetch_scheduler.md
FB_FETCH_SCHEDULER -- requirements
Module: fb_fetch_scheduler

Interface
REQ-001 Parameter FB0_BASE, 32'h81000000, byte base address of framebuffer 0.
REQ-002 Parameter FB1_BASE, 32'h8112C000, byte base address of framebuffer 1 (FB0_BASE + 640*480*4).
REQ-003 Parameter BURST_LEN, 64, beats per AXI read burst (64-bit beats, 2 pixels/beat).
REQ-004 Parameter BURSTS_PER_LINE, 5, bursts per 640-pixel scanline (320 beats).
REQ-005 Parameter MAX_OUTSTANDING, 2, maximum accepted-but-uncompleted bursts (1..3).
REQ-006 m00_axi_aclk  in  1  sole clock; all logic on rising edge.
REQ-007 m00_axi_areset  in  1  reset, asynchronous assert, active-high.
REQ-008 line_req  in  1  single-cycle pulse: fetch one scanline.
REQ-009 line_idx  in  9  scanline number, sampled with line_req; valid 0..479.
REQ-010 frame_start  in  1  single-cycle pulse at start of vertical blank.
REQ-011 swap_req  in  1  single-cycle pulse: display the other framebuffer from the next frame.
REQ-012 m00_axi_arid/araddr/arlen/arsize/arburst/arvalid  out  1/32/8/3/2/1  AXI4 AR channel.
REQ-013 m00_axi_arready  in  1  AR accept.
REQ-014 m00_axi_rvalid, m00_axi_rready, m00_axi_rlast  in  1 each  R-channel monitor only (block never drives R).
REQ-015 busy  out  1  line fetch in progress.
REQ-016 line_done  out  1  single-cycle pulse when last burst of a line completes.
REQ-017 active_fb  out  1  framebuffer currently displayed (0=fb0, 1=fb1).
REQ-018 swap_pending  out  1  swap requested, not yet applied.
REQ-019 err  out  1  sticky error flag; cleared only by reset.

Function
REQ-020 Constant AR fields: arid 0, arlen BURST_LEN-1 (8'd63), arsize 3'b011, arburst 2'b01 (INCR).
REQ-021 States: IDLE, ISSUE, DRAIN.
- IDLE -> ISSUE on line_req with line_idx<=479; latches line_idx, line_fb=active_fb, burst_idx=0.
REQ-022 Burst address: araddr = base(line_fb) + line_idx*2560 + burst_idx*512; 32-bit unsigned arithmetic, no wrap check.
REQ-023 ISSUE: arvalid high while burst_idx<BURSTS_PER_LINE and outstanding<MAX_OUTSTANDING.
- araddr/arvalid held stable until arready.
- arvalid never withdrawn before handshake.
REQ-024 AR handshake (arvalid&arready): burst_idx+1, outstanding+1; after handshake of burst 4 -> DRAIN.
REQ-025 Burst completion = rvalid&rready&rlast: outstanding-1.
- Same-cycle AR handshake and completion: outstanding unchanged.
REQ-026 DRAIN -> IDLE when outstanding reaches 0; line_done pulses in the cycle after the final completion.
REQ-027 busy = 1 in ISSUE and DRAIN, 0 in IDLE.
REQ-028 First arvalid appears 1 cycle after line_req.
REQ-029 line_req while busy: request dropped, err set, in-flight line unaffected.
REQ-030 line_req with line_idx>479: ignored, err set, stays IDLE.
REQ-031 swap_req sets swap_pending.
REQ-032 frame_start with swap_pending=1: active_fb toggles, swap_pending clears, same edge.
REQ-033 swap_req and frame_start in same cycle: swap applied at that frame_start.
REQ-034 Swap while busy affects only later lines; in-flight line keeps latched line_fb.
REQ-035 rlast completion with outstanding=0: ignored (no underflow), err set.

Reset
REQ-036 While m00_axi_areset=1:
- state IDLE, arvalid 0, araddr 0, busy 0, line_done 0, active_fb 0, swap_pending 0, err 0.
- outstanding 0, burst_idx 0.
REQ-037 Reset mid-line abandons the fetch; no further AR issued; post-reset R beats are ignored (REQ-035 not applied until next line_req).

Verification
REQ-038 Reset, line_req line_idx=0, arready tied 1, R slave 64 beats/burst -> araddr 0x81000000,0x81000200,...,0x81000800; line_done once; err 0.
REQ-039 line_idx=479, arready held 0 for 10 cycles -> arvalid high with araddr 0x8112B600 held stable throughout; never more than 2 outstanding.
REQ-040 swap_req, then frame_start, then line_req line_idx=1 -> active_fb=1, swap_pending=0, first araddr 0x8112CA00.
REQ-041 line_req during busy -> err=1; exactly 5 AR handshakes for original line.
REQ-042 line_idx=480 -> no arvalid, err=1, busy stays 0.
REQ-043 Assert reset after 2nd AR handshake -> all outputs at REQ-036 values next cycle; new line_req restarts at burst 0.
